// File: rtl/mfcc_frame_serializer.sv
// Serializes one MFCC coefficient frame per packet: header, sequence number,
// coefficients MSB-first, XOR checksum. One pending frame is buffered behind the active one.
module mfcc_frame_serializer #(
    parameter int          NUM_COEFFICIENTS = 13,
    parameter int          COEF_WIDTH       = 16,
    parameter logic [7:0]  HEADER_BYTE      = 8'hA5
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        mfcc_done_i,
    input  logic [NUM_COEFFICIENTS-1:0][COEF_WIDTH-1:0] mfcc_data_i,
    output logic [7:0]                                  tx_data_o,
    output logic                                        tx_valid_o,
    input  logic                                        tx_ready_i,
    input  logic                                        clear_ovf_i,
    output logic                                        busy_o,
    output logic                                        overflow_o,
    output logic [7:0]                                  drop_count_o
);

    localparam int IDX_W = (NUM_COEFFICIENTS > 1) ? $clog2(NUM_COEFFICIENTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFFICIENTS - 1);

    typedef logic [NUM_COEFFICIENTS-1:0][COEF_WIDTH-1:0] frame_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        SEQ  = 3'd2,
        CHI  = 3'd3,
        CLO  = 3'd4,
        CHK  = 3'd5
    } state_t;

    function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] data);
        return chk ^ data;
    endfunction

    state_t           state_r;
    frame_t           active_r;
    frame_t           pending_r;
    logic             pend_v_r;
    logic [7:0]       seq_r;
    logic [IDX_W-1:0] idx_r;
    logic [7:0]       chk_r;

    logic hs_s;
    logic capture_s;
    logic vacate_s;
    logic to_pend_s;
    logic drop_s;
    logic pend_v_nxt_s;
    logic active_nxt_s;
    logic busy_nxt_s;

    // Frame routing decisions: capture into active, park in pending, or drop.
    always_comb begin
        hs_s         = tx_valid_o && tx_ready_i;
        capture_s    = 1'b0;
        vacate_s     = 1'b0;
        to_pend_s    = 1'b0;
        drop_s       = 1'b0;
        pend_v_nxt_s = pend_v_r;
        active_nxt_s = 1'b0;
        busy_nxt_s   = 1'b0;

        if (state_r == IDLE) begin
            vacate_s     = pend_v_r;
            capture_s    = !pend_v_r && mfcc_done_i;
            active_nxt_s = capture_s || vacate_s;
        end else begin
            vacate_s     = 1'b0;
            capture_s    = 1'b0;
            active_nxt_s = !((state_r == CHK) && hs_s);
        end

        // Pending vacated this cycle can immediately accept the new frame.
        if (mfcc_done_i && !capture_s) begin
            if (!pend_v_r || vacate_s) begin
                to_pend_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            to_pend_s = 1'b0;
            drop_s    = 1'b0;
        end

        if (to_pend_s) begin
            pend_v_nxt_s = 1'b1;
        end else if (vacate_s) begin
            pend_v_nxt_s = 1'b0;
        end else begin
            pend_v_nxt_s = pend_v_r;
        end

        busy_nxt_s = active_nxt_s || pend_v_nxt_s;
    end

    // Packet FSM, buffers and drop bookkeeping with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            active_r     <= '0;
            pending_r    <= '0;
            pend_v_r     <= 1'b0;
            seq_r        <= 8'd0;
            idx_r        <= '0;
            chk_r        <= 8'd0;
            tx_data_o    <= 8'd0;
            tx_valid_o   <= 1'b0;
            busy_o       <= 1'b0;
            overflow_o   <= 1'b0;
            drop_count_o <= 8'd0;
        end else begin
            busy_o   <= busy_nxt_s;
            pend_v_r <= pend_v_nxt_s;
            if (to_pend_s) begin
                pending_r <= mfcc_data_i;
            end

            // A drop coinciding with a clear restarts the count at one.
            if (drop_s) begin
                overflow_o <= 1'b1;
                if (clear_ovf_i) begin
                    drop_count_o <= 8'd1;
                end else if (drop_count_o != 8'hFF) begin
                    drop_count_o <= drop_count_o + 8'd1;
                end
            end else if (clear_ovf_i) begin
                overflow_o   <= 1'b0;
                drop_count_o <= 8'd0;
            end

            case (state_r)
                IDLE: begin
                    if (capture_s || vacate_s) begin
                        active_r   <= capture_s ? mfcc_data_i : pending_r;
                        state_r    <= HDR;
                        tx_valid_o <= 1'b1;
                        tx_data_o  <= HEADER_BYTE;
                        chk_r      <= HEADER_BYTE;
                        idx_r      <= '0;
                    end else begin
                        tx_valid_o <= 1'b0;
                        tx_data_o  <= 8'd0;
                    end
                end
                HDR: begin
                    if (hs_s) begin
                        state_r   <= SEQ;
                        tx_data_o <= seq_r;
                    end
                end
                SEQ: begin
                    if (hs_s) begin
                        state_r   <= CHI;
                        chk_r     <= chk_update(chk_r, tx_data_o);
                        tx_data_o <= active_r[0][COEF_WIDTH-1 -: 8];
                    end
                end
                CHI: begin
                    if (hs_s) begin
                        state_r   <= CLO;
                        chk_r     <= chk_update(chk_r, tx_data_o);
                        tx_data_o <= active_r[idx_r][7:0];
                    end
                end
                CLO: begin
                    if (hs_s) begin
                        chk_r <= chk_update(chk_r, tx_data_o);
                        if (idx_r < LAST_IDX) begin
                            idx_r     <= idx_r + 1'b1;
                            state_r   <= CHI;
                            tx_data_o <= active_r[idx_r + 1'b1][COEF_WIDTH-1 -: 8];
                        end else begin
                            state_r   <= CHK;
                            tx_data_o <= chk_update(chk_r, tx_data_o);
                        end
                    end
                end
                CHK: begin
                    if (hs_s) begin
                        state_r    <= IDLE;
                        tx_valid_o <= 1'b0;
                        tx_data_o  <= 8'd0;
                        idx_r      <= '0;
                        seq_r      <= seq_r + 8'd1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    tx_valid_o <= 1'b0;
                    tx_data_o  <= 8'd0;
                    idx_r      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfcc_frame_serializer.sv
// Self-checking bench: table-driven packets, directed corner sequences and
// randomized traffic scored against a byte-queue packet model.
module tb_mfcc_frame_serializer;

    localparam int N = 13;
    typedef logic [N-1:0][15:0] frame_t;

    logic       clk;
    logic       rst_n;
    logic       mfcc_done_i;
    frame_t     mfcc_data_i;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic       clear_ovf_i;
    logic       busy_o;
    logic       overflow_o;
    logic [7:0] drop_count_o;

    int vectors = 0;
    int miscompares = 0;

    mfcc_frame_serializer #(
        .NUM_COEFFICIENTS(N),
        .COEF_WIDTH(16),
        .HEADER_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mfcc_done_i(mfcc_done_i),
        .mfcc_data_i(mfcc_data_i),
        .tx_data_o(tx_data_o),
        .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i),
        .clear_ovf_i(clear_ovf_i),
        .busy_o(busy_o),
        .overflow_o(overflow_o),
        .drop_count_o(drop_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: whole packets as byte queues, at most one pending frame.
    logic [7:0] m_pkt[$];
    int         m_pos;
    bit         m_act;
    frame_t     m_pend_f;
    bit         m_pend_v;
    logic [7:0] m_seq;
    bit         m_ovf;
    int         m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void start_pkt(input frame_t f);
        logic [7:0] c;
        m_pkt.delete();
        m_pkt.push_back(8'hA5);
        m_pkt.push_back(m_seq);
        for (int i = 0; i < N; i++) begin
            m_pkt.push_back(f[i][15:8]);
            m_pkt.push_back(f[i][7:0]);
        end
        c = 8'h00;
        foreach (m_pkt[k]) c = c ^ m_pkt[k];
        m_pkt.push_back(c);
        m_pos = 0;
        m_act = 1'b1;
    endfunction

    function automatic void model_reset();
        m_pkt.delete();
        m_pos = 0; m_act = 1'b0; m_pend_v = 1'b0;
        m_seq = 8'd0; m_ovf = 1'b0; m_cnt = 0;
    endfunction

    function automatic void model_step(input bit done, input frame_t f, input bit rdy, input bit clr);
        bit drop;
        drop = 1'b0;
        if (!m_act) begin
            if (m_pend_v) begin
                start_pkt(m_pend_f);
                m_pend_v = 1'b0;
                if (done) begin m_pend_f = f; m_pend_v = 1'b1; end
            end else if (done) begin
                start_pkt(f);
            end
        end else begin
            if (done) begin
                if (!m_pend_v) begin m_pend_f = f; m_pend_v = 1'b1; end
                else drop = 1'b1;
            end
            if (rdy) begin
                m_pos++;
                if (m_pos == m_pkt.size()) begin
                    m_act = 1'b0;
                    m_seq = m_seq + 8'd1;
                end
            end
        end
        if (drop) begin
            m_ovf = 1'b1;
            m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
    endfunction

    // Cycle monitor: advance the model at each edge, compare just after it.
    initial begin
        logic       pre_v, pre_r;
        logic [7:0] pre_d;
        forever begin
            @(posedge clk);
            pre_v = tx_valid_o; pre_r = tx_ready_i; pre_d = tx_data_o;
            if (!rst_n) model_reset();
            else model_step(mfcc_done_i, mfcc_data_i, tx_ready_i, clear_ovf_i);
            #1;
            check("valid", 32'(tx_valid_o), 32'(m_act));
            check("busy", 32'(busy_o), 32'(m_act || m_pend_v));
            check("overflow", 32'(overflow_o), 32'(m_ovf));
            check("drop_count", 32'(drop_count_o), 32'(m_cnt));
            if (m_act) check("data", 32'(tx_data_o), 32'(m_pkt[m_pos]));
            if (rst_n && pre_v && !pre_r) check("hold", 32'(tx_data_o), 32'(pre_d));
        end
    end

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < N; i++) f[i] = 16'($urandom);
        return f;
    endfunction

    task automatic pulse(input frame_t f);
        @(negedge clk);
        mfcc_done_i = 1'b1;
        mfcc_data_i = f;
        @(negedge clk);
        mfcc_done_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_act || m_pend_v) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(m_act || m_pend_v), 32'd0);
    endtask

    task automatic wait_pos(input int target, input int budget);
        int n = 0;
        while (!(m_act && m_pos == target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("pos_timeout", 32'(m_act && m_pos == target), 32'd1);
    endtask

    typedef struct {
        logic [15:0] c0;
        logic [15:0] clast;
        logic [7:0]  exp_chk;
        int          exp_len;
    } vec_t;

    initial begin
        vec_t   tbl[4];
        frame_t f;
        int     cnt;
        logic [7:0] last;

        // Checksums hand-computed for seq 0..3 with all middle coefficients zero.
        tbl[0] = '{16'h1234, 16'h0000, 8'h83, 29};
        tbl[1] = '{16'h0000, 16'hFFFF, 8'hA4, 29};
        tbl[2] = '{16'hABCD, 16'h0001, 8'hC0, 29};
        tbl[3] = '{16'h00FF, 16'hFF00, 8'hA6, 29};

        rst_n = 1'b0; mfcc_done_i = 1'b0; mfcc_data_i = '0;
        tx_ready_i = 1'b0; clear_ovf_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tx_ready_i = 1'b1;

        for (int r = 0; r < 4; r++) begin
            f = '0;
            f[0] = tbl[r].c0;
            f[N-1] = tbl[r].clast;
            pulse(f);
            cnt = 0; last = 8'h00;
            for (int c = 0; c < 100; c++) begin
                if (tx_valid_o) begin cnt++; last = tx_data_o; end
                else if (cnt > 0) break;
                @(negedge clk);
            end
            check("tbl_len", 32'(cnt), 32'(tbl[r].exp_len));
            check("tbl_chk", 32'(last), 32'(tbl[r].exp_chk));
            wait_idle(100);
        end

        // Backpressure on the basic frame.
        f = '0; f[0] = 16'h1234;
        pulse(f);
        while (m_act) begin
            @(negedge clk);
            tx_ready_i = 1'($urandom_range(0, 1));
        end
        tx_ready_i = 1'b1;
        wait_idle(200);

        // Three frames five cycles apart: third is dropped.
        pulse(rand_frame()); repeat (4) @(negedge clk);
        pulse(rand_frame()); repeat (4) @(negedge clk);
        pulse(rand_frame());
        check("b2b_ovf", 32'(overflow_o), 32'd1);
        check("b2b_cnt", 32'(drop_count_o), 32'd1);
        wait_idle(200);
        @(negedge clk) clear_ovf_i = 1'b1;
        @(negedge clk) clear_ovf_i = 1'b0;
        check("clr_ovf", 32'(overflow_o), 32'd0);
        check("clr_cnt", 32'(drop_count_o), 32'd0);

        // Frame arriving on the checksum handshake.
        pulse(rand_frame());
        wait_pos(28, 100);
        mfcc_done_i = 1'b1; mfcc_data_i = rand_frame();
        @(negedge clk) mfcc_done_i = 1'b0;
        check("gap_idle", 32'(tx_valid_o), 32'd0);
        @(negedge clk);
        check("gap_hdr_v", 32'(tx_valid_o), 32'd1);
        check("gap_hdr_d", 32'(tx_data_o), 32'hA5);
        check("gap_ovf", 32'(overflow_o), 32'd0);
        wait_idle(200);

        // Randomized traffic with backpressure and clears.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            mfcc_done_i = ($urandom_range(0, 99) < 15);
            mfcc_data_i = rand_frame();
            tx_ready_i  = ($urandom_range(0, 99) < 70);
            clear_ovf_i = ($urandom_range(0, 99) < 3);
        end
        @(negedge clk);
        mfcc_done_i = 1'b0; tx_ready_i = 1'b1; clear_ovf_i = 1'b1;
        @(negedge clk) clear_ovf_i = 1'b0;
        wait_idle(200);

        // Continuous frames: seq wraps past 255, drop count saturates.
        for (int c = 0; c < 7900; c++) begin
            @(negedge clk);
            mfcc_done_i = 1'b1;
            mfcc_data_i = rand_frame();
        end
        @(negedge clk) mfcc_done_i = 1'b0;
        check("sat_cnt", 32'(drop_count_o), 32'd255);
        check("sat_ovf", 32'(overflow_o), 32'd1);
        wait_idle(200);

        // Reset in the middle of a packet.
        pulse(rand_frame());
        wait_pos(10, 100);
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(tx_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_cnt", 32'(drop_count_o), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        pulse(rand_frame());
        check("post_rst_hdr", 32'(tx_data_o), 32'hA5);
        @(negedge clk);
        check("post_rst_seq", 32'(tx_data_o), 32'h00);
        wait_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mfcc_frame_serializer.md
MFCC_FRAME_SERIALIZER -- requirements
Module: mfcc_frame_serializer

Interface
REQ-001 SHALL have parameter NUM_COEFFICIENTS, default 13, the number of coefficients per MFCC frame.
REQ-002 SHALL have parameter COEF_WIDTH, default 16, the coefficient width in bits; only 16 is supported.
REQ-003 SHALL have parameter HEADER_BYTE, default 8'hA5, the packet start marker.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port clk  input  1  -- system clock, all logic on its rising edge.
REQ-006 Port rst_n  input  1  -- asynchronous active-low reset.
REQ-007 Port mfcc_done_i  input  1  -- one-cycle pulse marking a valid coefficient frame.
REQ-008 Port mfcc_data_i  input  NUM_COEFFICIENTS x COEF_WIDTH  -- coefficient array, index 0 first; valid in the cycle mfcc_done_i is high.
REQ-009 Port tx_data_o  output  8  -- serialized byte.
REQ-010 Port tx_valid_o  output  1  -- tx_data_o is valid.
REQ-011 Port tx_ready_i  input  1  -- sink accepts the byte; a transfer occurs when tx_valid_o and tx_ready_i are both high.
REQ-012 Port clear_ovf_i  input  1  -- synchronous clear of overflow_o.
REQ-013 Port busy_o  output  1  -- high while in any state other than IDLE, or while a pending frame is held.
REQ-014 Port overflow_o  output  1  -- sticky flag: a frame was dropped.
REQ-015 Port drop_count_o  output  8  -- count of dropped frames; saturates at 255.

Function
REQ-016 Packet byte order SHALL be:
- HEADER_BYTE
- seq
- coef[0] MSB, coef[0] LSB, ... through coef[N-1] LSB
- chk = XOR of all preceding packet bytes
Total length is 2*N+3 bytes (29 at default).
REQ-017 The FSM SHALL have states IDLE, HDR, SEQ, CHI, CLO, CHK.
REQ-018 FSM transitions SHALL be:
- IDLE->HDR when a frame is loaded into the active buffer.
- HDR->SEQ->CHI->CLO on each handshake.
- CLO->CHI if coef index < N-1, else CLO->CHK.
- CHK->IDLE on handshake.
REQ-019 tx_valid_o SHALL be high exactly in HDR, SEQ, CHI, CLO and CHK.
REQ-020 tx_data_o SHALL hold stable while tx_valid_o=1 and tx_ready_i=0.
REQ-021 Non-handshake cycles SHALL NOT change state, index or checksum.
REQ-022 Buffering SHALL use one active buffer plus one pending buffer (valid flag pend_v).
REQ-023 In IDLE with pend_v=1, the block SHALL copy pending to active, clear pend_v and go to HDR.
REQ-024 In IDLE with pend_v=0 and mfcc_done_i=1, the block SHALL capture mfcc_data_i into active and go to HDR.
REQ-025 Latency: tx_valid_o SHALL rise on the cycle after the capture edge.
REQ-026 When not capturing into active, mfcc_done_i=1 with pend_v=0 SHALL write pending and set pend_v.
REQ-027 mfcc_done_i=1 while pend_v=1 and pending is not being vacated in the same cycle SHALL:
- drop the new frame;
- set overflow_o;
- increment drop_count_o, saturating at 255.
REQ-028 mfcc_done_i in the same IDLE cycle that vacates pending SHALL be written into pending (no drop).
REQ-029 mfcc_done_i in the same cycle as the CHK handshake SHALL go to pending if pend_v=0, else drop.
REQ-030 There SHALL be exactly one IDLE cycle between consecutive packets.
REQ-031 seq SHALL start at 0, increment by 1 after each completed CHK handshake, and wrap 255->0; dropped frames do not consume a seq value.
REQ-032 The checksum register SHALL load HEADER_BYTE on entering HDR and XOR in each byte on its handshake, excluding chk.
REQ-033 clear_ovf_i SHALL clear overflow_o and drop_count_o.
REQ-034 A drop in the same cycle as clear_ovf_i SHALL leave overflow_o=1 and drop_count_o=1.

Reset
REQ-035 rst_n=0 SHALL asynchronously force:
- state IDLE, pend_v=0, seq=0, index=0, checksum=0;
- tx_valid_o=0, tx_data_o=0, busy_o=0, overflow_o=0, drop_count_o=0.
REQ-036 Reset mid-packet SHALL abort the packet, with no partial continuation after release.
REQ-037 The first mfcc_done_i after reset release SHALL produce a packet with seq=0.

Verification
REQ-038 Basic packet: coef[0]=16'h1234, others 0, tx_ready_i=1 -> bytes A5,00,12,34, then 24 x 00, then chk 83; tx_valid_o high for exactly 29 cycles.
REQ-039 Backpressure: toggle tx_ready_i randomly during the REQ-038 frame -> identical byte sequence; tx_data_o never changes while valid && !ready.
REQ-040 Back-to-back: three done pulses 5 cycles apart with tx_ready_i=1 -> frames 1 and 2 sent (seq 0,1), frame 3 dropped, overflow_o=1, drop_count_o=1; clear_ovf_i -> both 0.
REQ-041 Boundary: done coincident with the CHK handshake, pend_v=0 -> next HDR follows after exactly one IDLE cycle, seq=1, no drop.
REQ-042 Wrap and saturation: 256 packets -> seq of packet 257 is 00; 300 forced drops -> drop_count_o stays at 255.
REQ-043 Reset mid-packet: assert rst_n=0 at byte 10 -> tx_valid_o=0 immediately; next frame starts with A5,00.
